// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: pipeline-stage operand/producer info in, stall/forward controls out.
interface hazard_ctrl_if;
  // D-stage consumer
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [1:0]  TuseRsD;
  logic [1:0]  TuseRtD;
  logic        mdUseD;
  // E-stage consumer / producer
  logic [4:0]  rsE;
  logic [4:0]  rtE;
  logic        regWriteE;
  logic [4:0]  writeRegE;
  logic [1:0]  TnewE;
  logic        mdStartE;
  logic        mdIsDivE;
  // M-stage producer
  logic        regWriteM;
  logic [4:0]  writeRegM;
  logic [1:0]  TnewM;
  // W-stage producer
  logic        regWriteW;
  logic [4:0]  writeRegW;
  // Controls back to the pipeline
  logic        stall;
  logic        clrE;
  logic [1:0]  fwdRsD;
  logic [1:0]  fwdRtD;
  logic [1:0]  fwdRsE;
  logic [1:0]  fwdRtE;
  logic        mdBusy;
  logic [31:0] stallCnt;

  // Pipeline side
  modport master (
    output rsD, rtD, TuseRsD, TuseRtD, mdUseD, rsE, rtE, regWriteE, writeRegE, TnewE,
           mdStartE, mdIsDivE, regWriteM, writeRegM, TnewM, regWriteW, writeRegW,
    input  stall, clrE, fwdRsD, fwdRtD, fwdRsE, fwdRtE, mdBusy, stallCnt
  );

  // Hazard unit side
  modport slave (
    input  rsD, rtD, TuseRsD, TuseRtD, mdUseD, rsE, rtE, regWriteE, writeRegE, TnewE,
           mdStartE, mdIsDivE, regWriteM, writeRegM, TnewM, regWriteW, writeRegW,
    output stall, clrE, fwdRsD, fwdRtD, fwdRsE, fwdRtE, mdBusy, stallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: Tuse/Tnew register stalls, HI/LO busy stalls, bypass selects,
// and a running stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  logic [CntW-1:0] mdCntQ, mdCntD;
  logic [31:0]     stallCntQ;
  logic            regStall, mdStall, stall, mdBusy;

  // A source stalls when its producer will not have the value ready by the time it is used.
  function automatic logic srcStall(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic weE, input logic [4:0] wrE, input logic [1:0] tnE,
                                    input logic weM, input logic [4:0] wrM, input logic [1:0] tnM);
    return (r != 5'd0) && (tuse != 2'd3) &&
           ((weE && (wrE == r) && (tnE > tuse)) || (weM && (wrM == r) && (tnM > tuse)));
  endfunction

  // D-stage bypass: nearest ready producer wins (E, then M, then W).
  function automatic logic [1:0] fwdSelD(input logic [4:0] r,
                                         input logic weE, input logic [4:0] wrE,
                                         input logic [1:0] tnE,
                                         input logic weM, input logic [4:0] wrM,
                                         input logic [1:0] tnM,
                                         input logic weW, input logic [4:0] wrW);
    if (r == 5'd0)                                return 2'd0;
    else if (weE && (wrE == r) && (tnE == 2'd0))  return 2'd3;
    else if (weM && (wrM == r) && (tnM == 2'd0))  return 2'd2;
    else if (weW && (wrW == r))                   return 2'd1;
    else                                          return 2'd0;
  endfunction

  // E-stage bypass: M, then W.
  function automatic logic [1:0] fwdSelE(input logic [4:0] r,
                                         input logic weM, input logic [4:0] wrM,
                                         input logic [1:0] tnM,
                                         input logic weW, input logic [4:0] wrW);
    if (r == 5'd0)                                return 2'd0;
    else if (weM && (wrM == r) && (tnM == 2'd0))  return 2'd2;
    else if (weW && (wrW == r))                   return 2'd1;
    else                                          return 2'd0;
  endfunction

  // Stall and forwarding decode, purely combinational.
  always_comb begin
    mdBusy   = (mdCntQ != '0) || bus.mdStartE;
    mdStall  = bus.mdUseD && mdBusy;
    regStall = srcStall(bus.rsD, bus.TuseRsD, bus.regWriteE, bus.writeRegE, bus.TnewE,
                        bus.regWriteM, bus.writeRegM, bus.TnewM) ||
               srcStall(bus.rtD, bus.TuseRtD, bus.regWriteE, bus.writeRegE, bus.TnewE,
                        bus.regWriteM, bus.writeRegM, bus.TnewM);
    stall    = regStall || mdStall;
  end

  assign bus.stall    = stall;
  assign bus.clrE     = stall;
  assign bus.mdBusy   = mdBusy;
  assign bus.stallCnt = stallCntQ;
  assign bus.fwdRsD   = fwdSelD(bus.rsD, bus.regWriteE, bus.writeRegE, bus.TnewE, bus.regWriteM,
                                bus.writeRegM, bus.TnewM, bus.regWriteW, bus.writeRegW);
  assign bus.fwdRtD   = fwdSelD(bus.rtD, bus.regWriteE, bus.writeRegE, bus.TnewE, bus.regWriteM,
                                bus.writeRegM, bus.TnewM, bus.regWriteW, bus.writeRegW);
  assign bus.fwdRsE   = fwdSelE(bus.rsE, bus.regWriteM, bus.writeRegM, bus.TnewM,
                                bus.regWriteW, bus.writeRegW);
  assign bus.fwdRtE   = fwdSelE(bus.rtE, bus.regWriteM, bus.writeRegM, bus.TnewM,
                                bus.regWriteW, bus.writeRegW);

  // HI/LO busy countdown; a start is only accepted when the unit is idle.
  always_comb begin
    mdCntD = mdCntQ;
    if (mdCntQ != '0) begin
      mdCntD = mdCntQ - 1'b1;
    end else if (bus.mdStartE) begin
      mdCntD = bus.mdIsDivE ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
    end
  end

  // State registers; reset overrides starts and stalls in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdCntQ    <= '0;
      stallCntQ <= '0;
    end else begin
      mdCntQ    <= mdCntD;
      stallCntQ <= stallCntQ + {31'd0, stall};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant-vector table, directed multi-cycle sequences, and random
// stimulus against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [1:0] TuseRsD, TuseRtD;
    logic       regWriteE; logic [4:0] writeRegE; logic [1:0] TnewE;
    logic       regWriteM; logic [4:0] writeRegM; logic [1:0] TnewM;
    logic       regWriteW; logic [4:0] writeRegW;
  } inT;

  typedef struct packed {
    inT         in;
    logic       expStall;
    logic [1:0] expRsD, expRtD, expRsE, expRtE;
  } vecT;

  int nVec = 0;
  int nBad = 0;

  // Model state: the HI/LO unit is busy for every cycle index below mdEnd.
  longint     cyc = 0;
  longint     mdEnd = 0;
  logic [31:0] mStall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic mBusy();
    return (cyc < mdEnd) || bus.mdStartE;
  endfunction

  function automatic logic mStallOf();
    logic [4:0] r [2];
    logic [1:0] tu [2];
    logic s;
    r[0] = bus.rsD; r[1] = bus.rtD; tu[0] = bus.TuseRsD; tu[1] = bus.TuseRtD;
    s = bus.mdUseD && mBusy();
    for (int x = 0; x < 2; x++) begin
      if (r[x] != 0 && tu[x] != 3) begin
        if (bus.regWriteE && bus.writeRegE == r[x] && bus.TnewE > tu[x]) s = 1'b1;
        if (bus.regWriteM && bus.writeRegM == r[x] && bus.TnewM > tu[x]) s = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [1:0] mFwdD(input logic [4:0] r);
    if (r == 0) return 0;
    if (bus.regWriteE && bus.writeRegE == r && bus.TnewE == 0) return 3;
    if (bus.regWriteM && bus.writeRegM == r && bus.TnewM == 0) return 2;
    if (bus.regWriteW && bus.writeRegW == r) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] mFwdE(input logic [4:0] r);
    if (r == 0) return 0;
    if (bus.regWriteM && bus.writeRegM == r && bus.TnewM == 0) return 2;
    if (bus.regWriteW && bus.writeRegW == r) return 1;
    return 0;
  endfunction

  task automatic modelCheck();
    chk("m_stall",    bus.stall,    mStallOf());
    chk("m_clrE",     bus.clrE,     mStallOf());
    chk("m_fwdRsD",   bus.fwdRsD,   mFwdD(bus.rsD));
    chk("m_fwdRtD",   bus.fwdRtD,   mFwdD(bus.rtD));
    chk("m_fwdRsE",   bus.fwdRsE,   mFwdE(bus.rsE));
    chk("m_fwdRtE",   bus.fwdRtE,   mFwdE(bus.rtE));
    chk("m_mdBusy",   bus.mdBusy,   mBusy());
    chk("m_stallCnt", bus.stallCnt, mStall);
  endtask

  task automatic modelUpdate();
    if (reset) begin
      mdEnd  = 0;
      mStall = 0;
    end else begin
      if (mStallOf()) mStall = mStall + 1;
      if (bus.mdStartE && cyc >= mdEnd) mdEnd = cyc + (bus.mdIsDivE ? DC : MC) + 1;
    end
    cyc++;
  endtask

  // Called at a negedge with inputs already applied.
  task automatic tick();
    #1;
    modelCheck();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic applyIn(input inT v);
    bus.rsD = v.rsD; bus.rtD = v.rtD; bus.rsE = v.rsE; bus.rtE = v.rtE;
    bus.TuseRsD = v.TuseRsD; bus.TuseRtD = v.TuseRtD;
    bus.regWriteE = v.regWriteE; bus.writeRegE = v.writeRegE; bus.TnewE = v.TnewE;
    bus.regWriteM = v.regWriteM; bus.writeRegM = v.writeRegM; bus.TnewM = v.TnewM;
    bus.regWriteW = v.regWriteW; bus.writeRegW = v.writeRegW;
  endtask

  task automatic clearIn();
    inT z;
    z = '0;
    applyIn(z);
    bus.mdUseD = 0; bus.mdStartE = 0; bus.mdIsDivE = 0;
  endtask

  task automatic doReset();
    clearIn();
    reset = 1;
    tick();
    reset = 0;
  endtask

  vecT tbl [8];
  inT  v;
  int  n;

  initial begin
    // Table of single-cycle decode vectors with constant expectations.
    v = '0; v.TuseRsD = 0; v.TuseRtD = 3; v.regWriteE = 1; v.writeRegE = 0; v.TnewE = 2;
    v.regWriteW = 1; v.writeRegW = 0;
    tbl[0] = '{v, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};                 // register 0 never hazards
    v = '0; v.rtE = 8; v.regWriteM = 1; v.writeRegM = 8; v.TnewM = 0;
    v.regWriteW = 1; v.writeRegW = 8; v.TuseRsD = 3; v.TuseRtD = 3;
    tbl[1] = '{v, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2};                 // M beats W in E
    v = '0; v.rsE = 9; v.rsD = 9; v.regWriteW = 1; v.writeRegW = 9;
    tbl[2] = '{v, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0};                 // W-only forward
    v = '0; v.rsD = 3; v.rsE = 3; v.regWriteE = 1; v.writeRegE = 3; v.TnewE = 0;
    v.regWriteM = 1; v.writeRegM = 3; v.TnewM = 0;
    tbl[3] = '{v, 1'b0, 2'd3, 2'd0, 2'd2, 2'd0};                 // E beats M in D
    v = '0; v.rtD = 4; v.TuseRtD = 3; v.regWriteE = 1; v.writeRegE = 4; v.TnewE = 2;
    tbl[4] = '{v, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};                 // unused operand
    v = '0; v.rtD = 6; v.TuseRtD = 0; v.regWriteM = 1; v.writeRegM = 6; v.TnewM = 1;
    tbl[5] = '{v, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};                 // M-stage stall
    v = '0; v.rsD = 7; v.TuseRsD = 1; v.regWriteE = 1; v.writeRegE = 7; v.TnewE = 1;
    tbl[6] = '{v, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};                 // Tnew == Tuse is fine
    v = '0; v.rsD = 7; v.TuseRsD = 0; v.regWriteE = 0; v.writeRegE = 7; v.TnewE = 2;
    tbl[7] = '{v, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};                 // no write, no stall

    // First reset: state is unknown until the edge, so no model check yet.
    clearIn();
    reset = 1;
    @(negedge clk);
    @(posedge clk);
    mdEnd = 0; mStall = 0; cyc++;
    @(negedge clk);
    reset = 0;
    #1;
    chk("reset_mdBusy", bus.mdBusy, 0);
    chk("reset_stallCnt", bus.stallCnt, 0);

    for (int i = 0; i < 8; i++) begin
      applyIn(tbl[i].in);
      #1;
      chk($sformatf("tbl%0d_stall", i), bus.stall, tbl[i].expStall);
      chk($sformatf("tbl%0d_clrE", i), bus.clrE, tbl[i].expStall);
      chk($sformatf("tbl%0d_fwdRsD", i), bus.fwdRsD, tbl[i].expRsD);
      chk($sformatf("tbl%0d_fwdRtD", i), bus.fwdRtD, tbl[i].expRtD);
      chk($sformatf("tbl%0d_fwdRsE", i), bus.fwdRsE, tbl[i].expRsE);
      chk($sformatf("tbl%0d_fwdRtE", i), bus.fwdRtE, tbl[i].expRtE);
      tick();
    end

    // Load-use: producer moves E -> M and becomes ready.
    doReset();
    bus.rsD = 5; bus.TuseRsD = 0; bus.TuseRtD = 3;
    bus.regWriteE = 1; bus.writeRegE = 5; bus.TnewE = 2;
    #1; chk("lu_e_stall", bus.stall, 1); chk("lu_e_clrE", bus.clrE, 1);
    tick();
    bus.regWriteE = 0; bus.regWriteM = 1; bus.writeRegM = 5; bus.TnewM = 1;
    #1; chk("lu_m1_stall", bus.stall, 1);
    tick();
    bus.TnewM = 0;
    #1; chk("lu_m0_stall", bus.stall, 0); chk("lu_m0_fwdRsD", bus.fwdRsD, 2);
    chk("lu_stallCnt", bus.stallCnt, 2);
    tick();

    // Divide with a HI/LO consumer waiting in D.
    doReset();
    bus.mdUseD = 1; bus.mdStartE = 1; bus.mdIsDivE = 1; bus.TuseRsD = 3; bus.TuseRtD = 3;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (!bus.stall) break;
      n++;
      tick();
      if (k == 0) begin bus.mdStartE = 0; bus.mdIsDivE = 0; end
    end
    chk("div_stall_cycles", n, 11);
    chk("div_stallCnt", bus.stallCnt, 11);
    bus.mdUseD = 0;
    tick();

    // Reset two cycles into a multiply aborts it.
    doReset();
    bus.mdStartE = 1; bus.TuseRsD = 3; bus.TuseRtD = 3;
    tick();
    bus.mdStartE = 0;
    tick();
    reset = 1; bus.mdUseD = 1;
    #1; chk("rst_comb_stall", bus.stall, 1);
    tick();
    reset = 0; bus.mdUseD = 0;
    #1; chk("rst_abort_mdBusy", bus.mdBusy, 0); chk("rst_abort_stallCnt", bus.stallCnt, 0);
    tick();

    // A second start while busy is ignored.
    bus.mdStartE = 1; bus.mdIsDivE = 0;
    tick();
    bus.mdIsDivE = 1;
    tick();
    bus.mdStartE = 0; bus.mdIsDivE = 0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (!bus.mdBusy) break;
      n++;
      tick();
    end
    chk("busy_restart_ignored", n, MC - 1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      reset          = ($urandom_range(0, 39) == 0);
      bus.rsD        = 5'($urandom_range(0, 3));
      bus.rtD        = 5'($urandom_range(0, 3));
      bus.rsE        = 5'($urandom_range(0, 3));
      bus.rtE        = 5'($urandom_range(0, 3));
      bus.TuseRsD    = 2'($urandom_range(0, 3));
      bus.TuseRtD    = 2'($urandom_range(0, 3));
      bus.regWriteE  = 1'($urandom_range(0, 1));
      bus.writeRegE  = 5'($urandom_range(0, 3));
      bus.TnewE      = 2'($urandom_range(0, 3));
      bus.regWriteM  = 1'($urandom_range(0, 1));
      bus.writeRegM  = 5'($urandom_range(0, 3));
      bus.TnewM      = 2'($urandom_range(0, 2));
      bus.regWriteW  = 1'($urandom_range(0, 1));
      bus.writeRegW  = 5'($urandom_range(0, 3));
      bus.mdUseD     = 1'($urandom_range(0, 1));
      bus.mdStartE   = ($urandom_range(0, 7) == 0);
      bus.mdIsDivE   = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameters MULT_CYC, default 5, meaning HI/LO busy cycles after a multiply starts.
REQ-002 The block SHALL have parameter DIV_CYC, default 10, meaning HI/LO busy cycles after a divide starts.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports rsD and rtD, input, 5 bits each: source registers of the D-stage instruction.
REQ-006 The block SHALL have ports TuseRsD and TuseRtD, input, 2 bits each: cycles until the operand is needed; 3 means unused.
REQ-007 The block SHALL have port mdUseD, input, 1 bit: the D instruction is mult, div, mfhi, mflo, mthi or mtlo.
REQ-008 The block SHALL have ports rsE and rtE, input, 5 bits each: source registers in E.
REQ-009 The block SHALL have ports regWriteE (1), writeRegE (5) and TnewE (2), inputs: the E-stage producer.
REQ-010 The block SHALL have ports mdStartE (1) and mdIsDivE (1), inputs: the E instruction starts a multiply or divide.
REQ-011 The block SHALL have ports regWriteM (1), writeRegM (5) and TnewM (2), inputs: the M-stage producer.
REQ-012 The block SHALL have ports regWriteW (1) and writeRegW (5), inputs: the W-stage producer.
REQ-013 The block SHALL have port stall, output, 1 bit: hold PC and the IF/ID register.
REQ-014 The block SHALL have port clrE, output, 1 bit: clear the ID/EX register, inserting a bubble.
REQ-015 The block SHALL have ports fwdRsD and fwdRtD, output, 2 bits each: D-stage operand select; 0 = regfile, 1 = W, 2 = M, 3 = E.
REQ-016 The block SHALL have ports fwdRsE and fwdRtE, output, 2 bits each: E-stage operand select; 0 = ID/EX value, 1 = W, 2 = M.
REQ-017 The block SHALL have port mdBusy, output, 1 bit: the HI/LO unit is busy.
REQ-018 The block SHALL have port stallCnt, output, 32 bits: running count of stall cycles.

Function
REQ-019 A register-stall term SHALL be asserted for operand X (rs or rt) when rXD != 0, TuseXD != 3, regWriteE is set, writeRegE == rXD, and TnewE > TuseXD.
REQ-020 The same term SHALL be asserted for the M-stage producer when regWriteM is set, writeRegM == rXD, and TnewM > TuseXD.
REQ-021 An MD-stall term SHALL be asserted when mdUseD & mdBusy.
REQ-022 stall SHALL equal the OR of all stall terms, combinationally.
REQ-023 clrE SHALL equal stall, so every stall cycle places a bubble in E.
REQ-024 mdCnt, an internal counter, SHALL load MULT_CYC (or DIV_CYC when mdIsDivE) at the rising edge where mdStartE=1 and mdCnt==0.
REQ-025 Otherwise, mdCnt SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-026 mdStartE asserted while mdCnt != 0 SHALL be ignored; the count continues unchanged.
REQ-027 mdBusy SHALL equal (mdCnt != 0) | mdStartE, combinationally, so the start cycle is already busy.
REQ-028 fwdXD priority SHALL be E, then M, then W: select 3 if regWriteE & writeRegE==rXD & TnewE==0; else 2 if regWriteM & writeRegM==rXD & TnewM==0; else 1 if regWriteW & writeRegW==rXD; else 0.
REQ-029 fwdXE priority SHALL be M, then W: select 2 if regWriteM & writeRegM==rXE & TnewM==0; else 1 if regWriteW & writeRegW==rXE; else 0.
REQ-030 Register 0 SHALL never be forwarded, so the select is 0 whenever rX == 0.
REQ-031 stallCnt SHALL increment by 1 at each rising edge where stall=1 and reset=0, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-032 When reset=1 at a rising edge, mdCnt SHALL be set to 0 and stallCnt SHALL be set to 0.
REQ-033 Reset SHALL take precedence over mdStartE and stall in the same cycle.
REQ-034 A reset during a multiply or divide SHALL abort it, so mdBusy=0 on the next cycle unless mdStartE=1.
REQ-035 Combinational outputs SHALL follow their inputs during reset.

Verification
REQ-036 Load-use: rsD=5, TuseRsD=0, regWriteE=1, writeRegE=5, TnewE=2 -> stall=1 and clrE=1; the next cycle (producer in M, TnewM=1) -> stall=1; the cycle after (TnewM=0) -> stall=0 and fwdRsD=2.
REQ-037 ALU forward: rtE=8, regWriteM=1, writeRegM=8, TnewM=0, regWriteW=1, writeRegW=8 -> fwdRtE=2 (M wins over W).
REQ-038 Register 0: rsD=0, regWriteE=1, writeRegE=0, TnewE=2, TuseRsD=0 -> stall=0 and fwdRsD=0.
REQ-039 Divide: mdStartE=1, mdIsDivE=1 for one cycle, with mdUseD=1 held -> stall=1 for exactly 11 consecutive cycles (start cycle plus 10), then 0; stallCnt=11.
REQ-040 Reset mid-multiply: reset pulsed 2 cycles after mult start -> mdBusy=0 and stallCnt=0 the following cycle; a second start while busy leaves mdCnt unchanged.
